ram_window_buf: RTL and testbench

- Parametrised successor to the flat parallel-load register block: same flattened par_in/par_out bus and whole-array load.
- Adds serial shift-in (sliding window), single-entry addressed write, an addressed read port, and occupancy tracking (count/full/empty).
- Sits between the stream source and the datapath that consumes a full window of RAM_SIZE words in parallel.

---
 rtl/ram_window_buf_if.sv | 35 +++
 rtl/ram_window_buf.sv | 102 ++++++++++
 tb/tb_ram_window_buf.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_window_buf_if.sv
// ram_window_buf_if: bundles the data/control signals of ram_window_buf.
//   master modport (stream source / consumer side):
//     drives  ld, par_in, shift_en, ser_in, wr_en, wr_addr, wr_data, rd_addr
//     samples rd_data, par_out, count, full, empty
//   slave modport (the buffer itself): the mirror image.
// Entry i of par_in/par_out occupies bits [i*BIT_SIZE +: BIT_SIZE].
interface ram_window_buf_if #(
    parameter int unsigned BIT_SIZE = 16,
    parameter int unsigned RAM_SIZE = 8,
    parameter int unsigned ADDR_W   = $clog2(RAM_SIZE)
);
    logic                         ld;
    logic [RAM_SIZE*BIT_SIZE-1:0] par_in;
    logic                         shift_en;
    logic [BIT_SIZE-1:0]          ser_in;
    logic                         wr_en;
    logic [ADDR_W-1:0]            wr_addr;
    logic [BIT_SIZE-1:0]          wr_data;
    logic [ADDR_W-1:0]            rd_addr;
    logic [BIT_SIZE-1:0]          rd_data;
    logic [RAM_SIZE*BIT_SIZE-1:0] par_out;
    logic [ADDR_W:0]              count;
    logic                         full;
    logic                         empty;

    modport master (
        output ld, par_in, shift_en, ser_in, wr_en, wr_addr, wr_data, rd_addr,
        input  rd_data, par_out, count, full, empty
    );

    modport slave (
        input  ld, par_in, shift_en, ser_in, wr_en, wr_addr, wr_data, rd_addr,
        output rd_data, par_out, count, full, empty
    );
endinterface

// File: rtl/ram_window_buf.sv
// ram_window_buf: RAM_SIZE x BIT_SIZE sliding-window buffer.
//   Entry 0 is the oldest word, entry RAM_SIZE-1 the newest. Per cycle exactly one
//   operation takes effect, in priority rst > ld > shift_en > wr_en; the rest are dropped.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset (entries, count and registered read go to 0)
//   bus  - ram_window_buf_if.slave: ld/par_in whole-array load, shift_en/ser_in serial
//          insert at the tail, wr_en/wr_addr/wr_data addressed write, rd_addr/rd_data
//          addressed read, par_out flat view of storage, count/full/empty occupancy.
// Build option:
//   RAM_WINDOW_BUF_RDREG_EN - when defined, rd_data is registered (one cycle latency,
//   pre-update contents on a same-edge write). Otherwise rd_data is combinational.
module ram_window_buf #(
    parameter int unsigned BIT_SIZE = 16,
    parameter int unsigned RAM_SIZE = 8,
    parameter int unsigned ADDR_W   = $clog2(RAM_SIZE)
) (
    input logic             clk,
    input logic             rst,
    ram_window_buf_if.slave bus
);
    localparam logic [ADDR_W:0] CountMax = (ADDR_W + 1)'(RAM_SIZE);
    localparam logic [ADDR_W:0] CountOne = (ADDR_W + 1)'(1);

    logic [BIT_SIZE-1:0] mem_q [RAM_SIZE];
    logic [BIT_SIZE-1:0] mem_d [RAM_SIZE];
    logic [ADDR_W:0]     count_q;
    logic [ADDR_W:0]     count_d;
    logic                wr_in_range;
    logic                rd_in_range;
    logic [BIT_SIZE-1:0] rd_raw;

    // RAM_SIZE need not be a power of two, so the address space can exceed the storage.
    assign wr_in_range = 32'(bus.wr_addr) < RAM_SIZE;
    assign rd_in_range = 32'(bus.rd_addr) < RAM_SIZE;

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (bus.ld) begin
            for (int i = 0; i < RAM_SIZE; i++) begin
                mem_d[i] = bus.par_in[i*BIT_SIZE +: BIT_SIZE];
            end
            count_d = CountMax;
        end else if (bus.shift_en) begin
            // Oldest word falls off entry 0 when the window is already full.
            for (int i = 0; i < RAM_SIZE - 1; i++) begin
                mem_d[i] = mem_q[i+1];
            end
            mem_d[RAM_SIZE-1] = bus.ser_in;
            if (count_q != CountMax) begin
                count_d = count_q + CountOne;
            end
        end else if (bus.wr_en && wr_in_range) begin
            mem_d[bus.wr_addr] = bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RAM_SIZE; i++) begin
                mem_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        rd_raw = '0;
        if (rd_in_range) begin
            rd_raw = mem_q[bus.rd_addr];
        end
    end

`ifdef RAM_WINDOW_BUF_RDREG_EN
    logic [BIT_SIZE-1:0] rd_q;

    // Samples current storage, so a same-edge write is not visible here.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_raw;
        end
    end

    assign bus.rd_data = rd_q;
`else
    assign bus.rd_data = rd_raw;
`endif

    for (genvar g = 0; g < RAM_SIZE; g++) begin : g_par_out
        assign bus.par_out[g*BIT_SIZE +: BIT_SIZE] = mem_q[g];
    end

    assign bus.count = count_q;
    assign bus.full  = (count_q == CountMax);
    assign bus.empty = (count_q == '0);
endmodule

// File: tb/tb_ram_window_buf.sv
// Self-checking bench for ram_window_buf: directed vector table, hand-written corner
// sequences (write/read, no-bypass, mid-stream reset, non-power-of-two size) and a
// randomized run against a queue-based window model.
module tb_ram_window_buf;
    localparam int unsigned BW = 16;
    localparam int unsigned N  = 8;
    localparam int unsigned N6 = 6;

    typedef struct {
        bit          ld;
        bit          shift_en;
        logic [15:0] ser_in;
        bit          wr_en;
        logic [2:0]  wr_addr;
        logic [15:0] wr_data;
        logic [15:0] par_word;
        logic [3:0]  exp_count;
        logic [15:0] exp_e0;
        logic [15:0] exp_e7;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [BW-1:0] win[$];
    int unsigned   mcount;
    logic [BW-1:0] exp_rd;
    vec_t          vecs[12];

    always #5 clk = ~clk;

    ram_window_buf_if #(.BIT_SIZE(BW), .RAM_SIZE(N), .ADDR_W(3)) bus ();
    ram_window_buf_if #(.BIT_SIZE(BW), .RAM_SIZE(N6), .ADDR_W(3)) bus6 ();

    ram_window_buf #(.BIT_SIZE(BW), .RAM_SIZE(N), .ADDR_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    ram_window_buf #(.BIT_SIZE(BW), .RAM_SIZE(N6), .ADDR_W(3)) dut6 (
        .clk(clk),
        .rst(rst),
        .bus(bus6.slave)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit l, bit s, logic [15:0] ser, bit w, logic [2:0] wa,
                                logic [15:0] wd, logic [15:0] pw, logic [3:0] c,
                                logic [15:0] e0, logic [15:0] e7);
        vec_t v;
        v.ld = l; v.shift_en = s; v.ser_in = ser; v.wr_en = w; v.wr_addr = wa;
        v.wr_data = wd; v.par_word = pw; v.exp_count = c; v.exp_e0 = e0; v.exp_e7 = e7;
        return v;
    endfunction

    // Window model: a queue of N words, oldest at the front.
    task automatic model_step(input bit r, input bit l, input logic [N*BW-1:0] pin,
                              input bit s, input logic [BW-1:0] ser, input bit w,
                              input int unsigned wa, input logic [BW-1:0] wd);
        if (r) begin
            win = {};
            repeat (N) win.push_back('0);
            mcount = 0;
        end else if (l) begin
            for (int i = 0; i < N; i++) win[i] = pin[i*BW +: BW];
            mcount = N;
        end else if (s) begin
            win.push_back(ser);
            void'(win.pop_front());
            if (mcount < N) mcount++;
        end else if (w && wa < N) begin
            win[wa] = wd;
        end
    endtask

    function automatic logic [BW-1:0] model_rd(int unsigned a);
        return (a < N) ? win[a] : '0;
    endfunction

    function automatic logic [N*BW-1:0] model_flat();
        logic [N*BW-1:0] f;
        for (int i = 0; i < N; i++) f[i*BW +: BW] = win[i];
        return f;
    endfunction

    task automatic idle();
        bus.ld = 1'b0; bus.par_in = '0; bus.shift_en = 1'b0; bus.ser_in = '0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    endtask

    // One clock edge on the main DUT with the model following the same inputs.
    task automatic cycle();
        bit r, l, s, w;
        logic [N*BW-1:0] pin;
        logic [BW-1:0] ser, wd, pre;
        int unsigned wa;
        r = rst; l = bus.ld; s = bus.shift_en; w = bus.wr_en;
        pin = bus.par_in; ser = bus.ser_in; wd = bus.wr_data; wa = bus.wr_addr;
        pre = model_rd(bus.rd_addr);
        @(posedge clk);
        #1;
        model_step(r, l, pin, s, ser, w, wa, wd);
`ifdef RAM_WINDOW_BUF_RDREG_EN
        exp_rd = r ? '0 : pre;
`else
        exp_rd = model_rd(bus.rd_addr);
`endif
    endtask

    task automatic check_state(input string name);
        chk({name, " count"}, bus.count, mcount);
        chk({name, " full"}, bus.full, mcount == N);
        chk({name, " empty"}, bus.empty, mcount == 0);
        chk({name, " par_out"}, bus.par_out, model_flat());
    endtask

    task automatic read_check(input logic [2:0] a, input logic [15:0] e, input string name);
        bus.rd_addr = a;
`ifdef RAM_WINDOW_BUF_RDREG_EN
        cycle();
`else
        #1;
`endif
        chk(name, bus.rd_data, e);
    endtask

    task automatic read_check6(input logic [2:0] a, input logic [15:0] e, input string name);
        bus6.rd_addr = a;
`ifdef RAM_WINDOW_BUF_RDREG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
        chk(name, bus6.rd_data, e);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        bus.rd_addr = '0;
        bus6.ld = 1'b0; bus6.par_in = '0; bus6.shift_en = 1'b0; bus6.ser_in = '0;
        bus6.wr_en = 1'b0; bus6.wr_addr = '0; bus6.wr_data = '0; bus6.rd_addr = '0;
        model_step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 0, '0);

        // Reset then idle
        cycle();
        rst = 1'b0;
        check_state("reset");
        for (int a = 0; a < N; a++) read_check(3'(a), 16'h0000, "reset rd_data");

        // Directed table: serial fill, shift while full, priority clashes
        for (int k = 0; k < 8; k++)
            vecs[k] = mk(1'b0, 1'b1, 16'(k + 1), 1'b0, 3'd0, 16'h0, 16'h0, 4'(k + 1),
                         (k == 7) ? 16'h0001 : 16'h0000, 16'(k + 1));
        vecs[8]  = mk(1'b0, 1'b1, 16'h0009, 1'b0, 3'd0, 16'h0, 16'h0, 4'd8, 16'h0002, 16'h0009);
        vecs[9]  = mk(1'b1, 1'b1, 16'h5555, 1'b1, 3'd3, 16'h1234, 16'hAAAA, 4'd8,
                      16'hAAAA, 16'hAAAA);
        vecs[10] = mk(1'b0, 1'b1, 16'h5555, 1'b1, 3'd7, 16'h1234, 16'h0, 4'd8,
                      16'hAAAA, 16'h5555);
        vecs[11] = mk(1'b0, 1'b0, 16'h0, 1'b1, 3'd0, 16'h0BEE, 16'h0, 4'd8, 16'h0BEE, 16'h5555);

        for (int k = 0; k < 12; k++) begin
            bus.ld = vecs[k].ld; bus.shift_en = vecs[k].shift_en; bus.ser_in = vecs[k].ser_in;
            bus.wr_en = vecs[k].wr_en; bus.wr_addr = vecs[k].wr_addr;
            bus.wr_data = vecs[k].wr_data; bus.par_in = {N{vecs[k].par_word}};
            cycle();
            idle();
            chk($sformatf("vec%0d count", k), bus.count, vecs[k].exp_count);
            chk($sformatf("vec%0d full", k), bus.full, vecs[k].exp_count == 4'd8);
            chk($sformatf("vec%0d entry0", k), bus.par_out[15:0], vecs[k].exp_e0);
            chk($sformatf("vec%0d entry7", k), bus.par_out[127:112], vecs[k].exp_e7);
            check_state($sformatf("vec%0d model", k));
            if (k == 7)
                chk("fill par_out", bus.par_out, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        end

        // Addressed write after reset leaves count at 0
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        bus.wr_en = 1'b1; bus.wr_addr = 3'd5; bus.wr_data = 16'hBEEF;
        cycle();
        idle();
        chk("wr count", bus.count, 0);
        chk("wr empty", bus.empty, 1);
        read_check(3'd5, 16'hBEEF, "wr rd_data");

        // Same-address read and write: old value, no bypass
        bus.rd_addr = 3'd5; bus.wr_en = 1'b1; bus.wr_addr = 3'd5; bus.wr_data = 16'h1111;
`ifdef RAM_WINDOW_BUF_RDREG_EN
        cycle();
        chk("rw no bypass", bus.rd_data, 16'hBEEF);
        idle();
        cycle();
        chk("rw after", bus.rd_data, 16'h1111);
`else
        #1;
        chk("rw no bypass", bus.rd_data, 16'hBEEF);
        cycle();
        chk("rw after", bus.rd_data, 16'h1111);
`endif
        idle();

        // Reset mid-stream with a shift request in the same cycle
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.shift_en = 1'b1; bus.ser_in = 16'(16'h0100 + k);
            cycle();
        end
        idle();
        chk("mid count5", bus.count, 5);
        rst = 1'b1; bus.shift_en = 1'b1; bus.ser_in = 16'hABCD;
        cycle();
        rst = 1'b0;
        idle();
        chk("mid rst count", bus.count, 0);
        chk("mid rst par_out", bus.par_out, 128'h0);
        check_state("mid rst");

        // Non-power-of-two size: out-of-range write ignored, read returns 0
        bus6.ld = 1'b1; bus6.par_in = 96'h0006_0005_0004_0003_0002_0001;
        @(posedge clk);
        #1;
        bus6.ld = 1'b0;
        chk("n6 count", bus6.count, 6);
        chk("n6 full", bus6.full, 1);
        bus6.wr_en = 1'b1; bus6.wr_addr = 3'd7; bus6.wr_data = 16'hFFFF;
        @(posedge clk);
        #1;
        bus6.wr_addr = 3'd6;
        @(posedge clk);
        #1;
        bus6.wr_en = 1'b0;
        chk("n6 oob write", bus6.par_out, 96'h0006_0005_0004_0003_0002_0001);
        chk("n6 count kept", bus6.count, 6);
        read_check6(3'd7, 16'h0000, "n6 rd 7");
        read_check6(3'd6, 16'h0000, "n6 rd 6");
        read_check6(3'd5, 16'h0006, "n6 rd 5");

        // Randomized run against the window model
        for (int t = 0; t < 600; t++) begin
            rst = ($urandom_range(39) == 0);
            bus.ld = ($urandom_range(9) == 0);
            bus.par_in = {$urandom, $urandom, $urandom, $urandom};
            bus.shift_en = 1'($urandom_range(1));
            bus.ser_in = 16'($urandom);
            bus.wr_en = 1'($urandom_range(1));
            bus.wr_addr = 3'($urandom_range(7));
            bus.wr_data = 16'($urandom);
            bus.rd_addr = 3'($urandom_range(7));
            cycle();
            check_state("rand");
            chk("rand rd_data", bus.rd_data, exp_rd);
        end
        rst = 1'b0;
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
